ads131_cmd_sequencer: RTL

ADS131_CMD_SEQUENCER -- requirements
Module: ads131_cmd_sequencer

---
 rtl/ads131_cmd_sequencer.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ads131_cmd_sequencer.sv
// ADS131 power-up command sequencer.
// Resets the ADC, polls until it reports ready, then writes the configuration
// registers one at a time, checking each acknowledgment on the following frame.
// Once configured it turns every data-ready falling edge into a single NULL frame.
module ads131_cmd_sequencer #(
    parameter logic [15:0] READY_WORD    = 16'hFF04,
    parameter logic [7:0]  A_SYS_CFG_VAL = 8'h60,
    parameter logic [7:0]  CLK1_VAL      = 8'h08,
    parameter logic [7:0]  CLK2_VAL      = 8'h86,
    parameter logic [7:0]  ADC_ENA_VAL   = 8'h0F,
    parameter int unsigned MAX_POLL      = 64
) (
    input  logic        synthesized_clock_4_167Mhz,
    input  logic        reset_n,
    input  logic        adc_init_i,
    input  logic        drdy_n_i,
    input  logic        xfer_busy_i,
    input  logic        xfer_done_i,
    input  logic [15:0] xfer_resp_i,
    output logic        xfer_start_o,
    output logic [15:0] xfer_cmd_o,
    output logic        init_done_o,
    output logic        init_error_o,
    output logic        sample_valid_o,
    output logic [2:0]  seq_state_o
);

    localparam int unsigned PollW = $clog2(MAX_POLL + 1);

    localparam logic [15:0] CmdReset  = 16'h0011;
    localparam logic [15:0] CmdNull   = 16'h0000;
    localparam logic [15:0] CmdUnlock = 16'h0655;
    localparam logic [15:0] CmdWakeup = 16'h0033;
    localparam logic [15:0] CmdLock   = 16'h0555;

    localparam logic [7:0] AddrASysCfg = 8'h0B;
    localparam logic [7:0] AddrClk1    = 8'h0D;
    localparam logic [7:0] AddrClk2    = 8'h0E;
    localparam logic [7:0] AddrAdcEna  = 8'h0F;

    localparam logic [2:0] LastStep = 3'd6;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StResetCmd = 3'd1,
        StPoll     = 3'd2,
        StCmd      = 3'd3,
        StCheck    = 3'd4,
        StRun      = 3'd5,
        StError    = 3'd6
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       step_q, step_d;
    logic [PollW-1:0] poll_q, poll_d;
    logic             out_q, out_d;
    logic [15:0]      cmd_q, cmd_d;
    logic             init_q;
    logic             drdy_s1_q, drdy_s2_q, drdy_prev_q;

    logic        init_rise;
    logic        honor_init;
    logic        done;
    logic        drdy_fall;
    logic        want_frame;
    logic        start;
    logic [15:0] frame_cmd;
    logic [15:0] table_cmd;
    logic [15:0] table_ack;

    // WREG command word and its acknowledgment share the address/data layout.
    function automatic logic [15:0] wreg_cmd(input logic [7:0] addr, input logic [7:0] data);
        return {8'h40 | addr, data};
    endfunction

    function automatic logic [15:0] wreg_ack(input logic [7:0] addr, input logic [7:0] data);
        return {8'h20 | addr, data};
    endfunction

    // Input conditioning: adc_init edge register and drdy_n synchronizer.
    always_ff @(posedge synthesized_clock_4_167Mhz or negedge reset_n) begin
        if (!reset_n) begin
            init_q      <= 1'b0;
            drdy_s1_q   <= 1'b1;
            drdy_s2_q   <= 1'b1;
            drdy_prev_q <= 1'b1;
        end else begin
            init_q      <= adc_init_i;
            drdy_s1_q   <= drdy_n_i;
            drdy_s2_q   <= drdy_s1_q;
            drdy_prev_q <= drdy_s2_q;
        end
    end

    assign init_rise = adc_init_i & ~init_q;
    assign drdy_fall = drdy_prev_q & ~drdy_s2_q;
    // A completion only counts when we actually have a frame in flight.
    assign done      = xfer_done_i & out_q;

    // Command table and the acknowledgment expected for each entry.
    always_comb begin
        table_cmd = CmdNull;
        table_ack = CmdNull;
        unique case (step_q)
            3'd0: begin
                table_cmd = CmdUnlock;
                table_ack = CmdUnlock;
            end
            3'd1: begin
                table_cmd = wreg_cmd(AddrASysCfg, A_SYS_CFG_VAL);
                table_ack = wreg_ack(AddrASysCfg, A_SYS_CFG_VAL);
            end
            3'd2: begin
                table_cmd = wreg_cmd(AddrClk1, CLK1_VAL);
                table_ack = wreg_ack(AddrClk1, CLK1_VAL);
            end
            3'd3: begin
                table_cmd = wreg_cmd(AddrClk2, CLK2_VAL);
                table_ack = wreg_ack(AddrClk2, CLK2_VAL);
            end
            3'd4: begin
                table_cmd = wreg_cmd(AddrAdcEna, ADC_ENA_VAL);
                table_ack = wreg_ack(AddrAdcEna, ADC_ENA_VAL);
            end
            3'd5: begin
                table_cmd = CmdWakeup;
                table_ack = CmdWakeup;
            end
            3'd6: begin
                table_cmd = CmdLock;
                table_ack = CmdLock;
            end
            default: begin
                table_cmd = CmdNull;
                table_ack = CmdNull;
            end
        endcase
    end

    // Which frame the current state wants to send, if any.
    always_comb begin
        want_frame = 1'b0;
        frame_cmd  = CmdNull;
        unique case (state_q)
            StResetCmd: begin
                want_frame = 1'b1;
                frame_cmd  = CmdReset;
            end
            StPoll, StCheck: begin
                want_frame = 1'b1;
                frame_cmd  = CmdNull;
            end
            StCmd: begin
                want_frame = 1'b1;
                frame_cmd  = table_cmd;
            end
            StRun: begin
                // Edges that land while a frame is in flight are dropped below.
                want_frame = drdy_fall;
                frame_cmd  = CmdNull;
            end
            default: begin
                want_frame = 1'b0;
                frame_cmd  = CmdNull;
            end
        endcase
    end

    assign honor_init = init_rise & ~out_q &
                        ((state_q == StIdle) | (state_q == StRun) | (state_q == StError));

    // A restart takes priority so a RUN frame never launches into RESET_CMD.
    assign start = want_frame & ~out_q & ~xfer_busy_i & ~honor_init;

    // Next-state logic: sequence advance, poll counting and outstanding tracking.
    always_comb begin
        state_d        = state_q;
        step_d         = step_q;
        poll_d         = poll_q;
        out_d          = out_q;
        cmd_d          = cmd_q;
        sample_valid_o = 1'b0;

        if (honor_init) begin
            state_d = StResetCmd;
            step_d  = 3'd0;
            poll_d  = '0;
        end else if (done) begin
            unique case (state_q)
                StResetCmd: state_d = StPoll;
                StPoll: begin
                    poll_d = poll_q + PollW'(1);
                    if (xfer_resp_i == READY_WORD) begin
                        state_d = StCmd;
                        step_d  = 3'd0;
                    end else if (poll_q == PollW'(MAX_POLL - 1)) begin
                        state_d = StError;
                    end
                end
                StCmd: state_d = StCheck;
                StCheck: begin
                    if (xfer_resp_i != table_ack) begin
                        state_d = StError;
                    end else if (step_q == LastStep) begin
                        state_d = StRun;
                    end else begin
                        step_d  = step_q + 3'd1;
                        state_d = StCmd;
                    end
                end
                StRun: sample_valid_o = 1'b1;
                default: state_d = state_q;
            endcase
        end

        // start needs out_q low and done needs it high, so they never coincide.
        if (start) begin
            out_d = 1'b1;
            cmd_d = frame_cmd;
        end else if (done) begin
            out_d = 1'b0;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge synthesized_clock_4_167Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            step_q  <= 3'd0;
            poll_q  <= '0;
            out_q   <= 1'b0;
            cmd_q   <= CmdNull;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            poll_q  <= poll_d;
            out_q   <= out_d;
            cmd_q   <= cmd_d;
        end
    end

    // Command is presented with the start pulse and then held from cmd_q.
    assign xfer_start_o = start;
    assign xfer_cmd_o   = start ? frame_cmd : cmd_q;
    assign init_done_o  = (state_q == StRun);
    assign init_error_o = (state_q == StError);
    assign seq_state_o  = state_q;

endmodule
